lcd_refresh_ctrl: RTL and testbench
===================================

LCD_REFRESH_CTRL -- requirements
Module: lcd_refresh_ctrl

Interface
REQ-001 Parameter T_POWERUP, default 1_000_000: power-up wait in clk cycles (20 ms @ 50 MHz).
REQ-002 Parameter T_EHIGH, default 25: LCD_E high time in cycles (500 ns).
REQ-003 Parameter T_CMD, default 2_500: post-pulse wait for normal command or character (50 us).
REQ-004 Parameter T_CLEAR, default 100_000: post-pulse wait after clear-display 0x01 (2 ms).
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  system clock (CLOCK_50 domain).
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 wr_en  in  1  frame-buffer write strobe, one byte per cycle.
REQ-009 wr_addr  in  5  character position: 0-15 line 1, 16-31 line 2.
REQ-010 wr_data  in  8  ASCII/CGROM code.
REQ-011 LCD_RS  out  1  HD44780 register select: 0 command, 1 data.
REQ-012 LCD_E  out  1  HD44780 enable strobe.
REQ-013 LCD_D  out  8  HD44780 data bus, 8-bit mode; RW is tied low externally.
REQ-014 init_done  out  1  high once the init sequence has completed.
REQ-015 frame_tick  out  1  one-cycle pulse after the last character of each full refresh pass.

Function
REQ-016 The 32x8 frame buffer SHALL accept writes whenever wr_en=1, in any state, with no backpressure.
REQ-017 The FSM SHALL have states PWR_WAIT, SETUP, E_HIGH, HOLD_WAIT.
- PWR_WAIT: count T_POWERUP, then go to SETUP with step=0.
- SETUP: drive RS/D for the current step for 1 cycle, then go to E_HIGH.
- E_HIGH: LCD_E=1 for T_EHIGH cycles, then go to HOLD_WAIT.
- HOLD_WAIT: LCD_E=0; wait T_CLEAR for command 0x01, otherwise T_CMD; then advance step and go to SETUP.
REQ-018 Init steps 0-4 SHALL issue commands 0x38, 0x38, 0x0C, 0x06, 0x01 in that order with RS=0.
REQ-019 init_done SHALL rise in the cycle the HOLD_WAIT of init step 4 ends, and stay high until reset.
REQ-020 The refresh pass SHALL be 34 steps:
- 0x80 (RS=0);
- characters 0-15 (RS=1);
- 0xC0 (RS=0);
- characters 16-31 (RS=1);
- then wrap to the 0x80 step indefinitely.
REQ-021 The character byte SHALL be read from the frame buffer in SETUP.
REQ-022 A write to the same address in that same cycle SHALL NOT affect the current pass; the new value SHALL appear on the next pass.
REQ-023 RS and D SHALL be stable from SETUP through the end of E_HIGH and the first HOLD_WAIT cycle (address/data hold).
REQ-024 frame_tick SHALL pulse in the cycle that the HOLD_WAIT of character 31 ends.
REQ-025 The wait counter SHALL be sized to $clog2 of the largest of T_POWERUP, T_CLEAR, T_CMD and T_EHIGH, and SHALL reload to zero on every state change.

Reset
REQ-026 On reset_n=0, regardless of state, the block SHALL immediately drive:
- LCD_E=0, LCD_RS=0, LCD_D=0x00;
- init_done=0, frame_tick=0;
- state PWR_WAIT, step 0, counter 0.
REQ-027 On reset, every frame-buffer entry SHALL be 0x20 (space).
REQ-028 After reset release, the full power-up and init sequence SHALL restart, including when reset was asserted mid-pulse or mid-refresh.

Structure
REQ-029 Package lcd_pkg SHALL hold:
- the state enum type;
- command constants CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY=0x06, CMD_CLEAR=0x01, CMD_LINE1=0x80, CMD_LINE2=0xC0;
- constants N_INIT=5, N_REFRESH=34.
REQ-030 The frame buffer SHALL be a sub-module lcd_frame_buffer (32x8, one write port, one combinational read port, reset to 0x20); the sequencer SHALL be in lcd_refresh_ctrl.

Verification (T_POWERUP=20, T_EHIGH=2, T_CMD=5, T_CLEAR=10)
REQ-031 Release reset, no writes:
- first E rise at cycle 21 with D=0x38, RS=0;
- five E pulses carrying 0x38, 0x38, 0x0C, 0x06, 0x01;
- 10-cycle gap after 0x01;
- init_done then rises.
REQ-032 Write "HELLO" at addresses 0-4 before init_done: first pass shows 0x80, then 'H','E','L','L','O', then 11x 0x20, then 0xC0, then 16x 0x20, all with correct RS.
REQ-033 Write 0x41 to address 17 in the SETUP cycle of character 17: that pass emits 0x20 at that position; the next pass emits 0x41.
REQ-034 Run two passes: frame_tick pulses exactly once per 34 steps, and the step after character 31 is 0x80.
REQ-035 Assert reset_n low during E_HIGH of a character: LCD_E drops in the same cycle (asynchronous); after release, PWR_WAIT repeats and the buffer reads all 0x20.
REQ-036 Check every pulse: E high for exactly 2 cycles, and RS/D never change while E=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared types and constants for the HD44780 refresh controller:
// sequencer state encoding, command bytes, sequence lengths and
// frame-buffer geometry.
package lcd_pkg;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int N_CHARS = 32;

    typedef enum logic [1:0] {
        PWR_WAIT,
        SETUP,
        E_HIGH,
        HOLD_WAIT
    } state_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam logic [7:0] CHAR_SPACE   = 8'h20;

    localparam int N_INIT     = 5;
    localparam int N_REFRESH  = 34;
    // Refresh step that re-addresses the cursor to line 2.
    localparam int LINE2_STEP = 17;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_refresh_ctrl_if.sv
// lcd_refresh_ctrl_if
// Bundles the frame-buffer write port and the HD44780 pin/status outputs.
//   wr_en/wr_addr/wr_data : host -> controller, one byte per cycle
//   LCD_RS/LCD_E/LCD_D    : controller -> panel (8-bit mode, RW tied low)
//   init_done/frame_tick  : controller -> host status
interface lcd_refresh_ctrl_if;
    import lcd_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              LCD_RS;
    logic              LCD_E;
    logic [DATA_W-1:0] LCD_D;
    logic              init_done;
    logic              frame_tick;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  LCD_RS, LCD_E, LCD_D, init_done, frame_tick
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output LCD_RS, LCD_E, LCD_D, init_done, frame_tick
    );

endinterface

// File: rtl/lcd_frame_buffer.sv
// lcd_frame_buffer
// 32x8 character store. One synchronous write port, one combinational
// read port; every entry resets to an ASCII space.
//   clk, reset_n      : clock, async active-low reset
//   wr_en/addr/data   : write port, no backpressure
//   rd_addr/rd_data   : combinational read port
module lcd_frame_buffer
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [N_CHARS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CHARS; i++) begin
                mem[i] <= CHAR_SPACE;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl
// Powers up an HD44780 in 8-bit mode, runs the five-command init, then
// continuously repaints both 16-character lines from the frame buffer.
//   clk, reset_n : clock (CLOCK_50 domain), async active-low reset
//   bus          : write port in, LCD pins and status out
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   PWR_WAIT  | panel power-up delay, all outputs idle
//   SETUP     | RS/D presented for the current step, E still low
//   E_HIGH    | E strobe high, RS/D held
//   HOLD_WAIT | E low, execution wait (long wait after clear-display)
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = 1_000_000,
    parameter int T_EHIGH   = 25,
    parameter int T_CMD     = 2_500,
    parameter int T_CLEAR   = 100_000
) (
    input  logic clk,
    input  logic reset_n,
    lcd_refresh_ctrl_if.slave bus
);

    localparam int T_MAX = max_int(max_int(T_POWERUP, T_CLEAR), max_int(T_CMD, T_EHIGH));
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [5:0]        step;
    logic              rs_q;
    logic              e_q;
    logic [DATA_W-1:0] d_q;
    logic              done_q;
    logic              tick_q;

    logic              cnt_end;
    logic [5:0]        nxt_step;
    logic              nxt_refresh;
    logic              nxt_rs;
    logic [DATA_W-1:0] nxt_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    lcd_frame_buffer u_fb (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // The byte on the bus decides the hold time: only a clear command
    // needs the long execution wait.
    always_comb begin
        cnt_end = 1'b0;
        case (state)
            PWR_WAIT:  cnt_end = (cnt == CNT_W'(T_POWERUP - 1));
            SETUP:     cnt_end = 1'b1;
            E_HIGH:    cnt_end = (cnt == CNT_W'(T_EHIGH - 1));
            HOLD_WAIT: cnt_end = (!rs_q && d_q == CMD_CLEAR) ? (cnt == CNT_W'(T_CLEAR - 1))
                                                             : (cnt == CNT_W'(T_CMD - 1));
            default:   cnt_end = 1'b0;
        endcase
    end

    // Step that the next SETUP will present.
    always_comb begin
        nxt_step    = 6'd0;
        nxt_refresh = done_q;
        if (state == HOLD_WAIT) begin
            if (!done_q) begin
                if (step == 6'(N_INIT - 1)) begin
                    nxt_refresh = 1'b1;
                end else begin
                    nxt_step = step + 6'd1;
                end
            end else if (step != 6'(N_REFRESH - 1)) begin
                nxt_step = step + 6'd1;
            end
        end
    end

    // Byte for the next step. Characters are captured on the edge that
    // enters SETUP, so a write landing during SETUP only shows next pass.
    always_comb begin
        nxt_rs  = 1'b0;
        nxt_d   = CMD_FUNC_SET;
        rd_addr = '0;
        if (!nxt_refresh) begin
            case (nxt_step)
                6'd0, 6'd1: nxt_d = CMD_FUNC_SET;
                6'd2:       nxt_d = CMD_DISP_ON;
                6'd3:       nxt_d = CMD_ENTRY;
                default:    nxt_d = CMD_CLEAR;
            endcase
        end else if (nxt_step == 6'd0) begin
            nxt_d = CMD_LINE1;
        end else if (nxt_step == 6'(LINE2_STEP)) begin
            nxt_d = CMD_LINE2;
        end else begin
            nxt_rs  = 1'b1;
            rd_addr = (nxt_step < 6'(LINE2_STEP)) ? ADDR_W'(nxt_step - 6'd1)
                                                  : ADDR_W'(nxt_step - 6'd2);
            nxt_d   = rd_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= PWR_WAIT;
            cnt    <= '0;
            step   <= 6'd0;
            rs_q   <= 1'b0;
            e_q    <= 1'b0;
            d_q    <= '0;
            done_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (cnt_end) begin
                cnt <= '0;
                case (state)
                    PWR_WAIT: begin
                        state <= SETUP;
                        step  <= 6'd0;
                        rs_q  <= nxt_rs;
                        d_q   <= nxt_d;
                    end
                    SETUP: begin
                        state <= E_HIGH;
                        e_q   <= 1'b1;
                    end
                    E_HIGH: begin
                        state <= HOLD_WAIT;
                        e_q   <= 1'b0;
                    end
                    HOLD_WAIT: begin
                        state  <= SETUP;
                        step   <= nxt_step;
                        rs_q   <= nxt_rs;
                        d_q    <= nxt_d;
                        done_q <= nxt_refresh;
                        tick_q <= done_q && (step == 6'(N_REFRESH - 1));
                    end
                    default: state <= PWR_WAIT;
                endcase
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.LCD_RS     = rs_q;
    assign bus.LCD_E      = e_q;
    assign bus.LCD_D      = d_q;
    assign bus.init_done  = done_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// tb_lcd_refresh_ctrl
// Self-checking bench: a step-schedule model predicts every output each
// cycle; directed scenarios add literal checks on timing and byte order.
module tb_lcd_refresh_ctrl;

    localparam int TP  = 20;
    localparam int TE  = 2;
    localparam int TC  = 5;
    localparam int TCL = 10;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    lcd_refresh_ctrl_if bus ();

    lcd_refresh_ctrl #(
        .T_POWERUP (TP),
        .T_EHIGH   (TE),
        .T_CMD     (TC),
        .T_CLEAR   (TCL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each step occupies 1 setup + TE strobe + hold cycles; steps start
    // back to back after TP power-up cycles. Cycle 0 is the one in which
    // reset is released.
    logic [7:0] shadow [32];
    int   mt = 0;
    int   mk = -1;
    int   m_start = 0;
    int   m_next  = TP;
    logic m_e = 1'b0, m_rs = 1'b0, m_done = 1'b0, m_tick = 1'b0;
    logic [7:0] m_d = 8'h00;

    function automatic void step_byte(input int k, output logic rs, output logic [7:0] d);
        int r, line, col;
        rs = 1'b0;
        d  = 8'h00;
        if (k < 5) begin
            case (k)
                0, 1:    d = 8'h38;
                2:       d = 8'h0C;
                3:       d = 8'h06;
                default: d = 8'h01;
            endcase
        end else begin
            r    = (k - 5) % 34;
            line = r / 17;
            col  = r % 17;
            if (col == 0) begin
                d = (line == 1) ? 8'hC0 : 8'h80;
            end else begin
                rs = 1'b1;
                d  = shadow[line * 16 + col - 1];
            end
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mt = 0; mk = -1; m_start = 0; m_next = TP;
            m_e = 1'b0; m_rs = 1'b0; m_d = 8'h00; m_done = 1'b0; m_tick = 1'b0;
            for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
        end else begin
            mt++;
            m_tick = 1'b0;
            if (mt == m_next) begin
                mk++;
                step_byte(mk, m_rs, m_d);
                m_start = mt;
                m_next  = mt + 1 + TE + ((!m_rs && m_d == 8'h01) ? TCL : TC);
                m_done  = (mk >= 5);
                m_tick  = (mk >= 39) && ((mk - 5) % 34 == 0);
            end
            m_e = (mk >= 0) && (mt - m_start >= 1) && (mt - m_start <= TE);
            if (bus.wr_en) shadow[bus.wr_addr] = bus.wr_data;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("LCD_E",      int'(bus.LCD_E),      int'(m_e));
        check("LCD_RS",     int'(bus.LCD_RS),     int'(m_rs));
        check("LCD_D",      int'(bus.LCD_D),      int'(m_d));
        check("init_done",  int'(bus.init_done),  int'(m_done));
        check("frame_tick", int'(bus.frame_tick), int'(m_tick));
    end

    // ---------------- pulse monitor ----------------
    int         cyc = 0;
    logic [8:0] pulses [$];
    logic [8:0] cap = '0;
    logic       prev_e = 1'b0, prev_done = 1'b0;
    int         width = 0;
    int         first_rise = -1, last_fall = -1, done_cyc = -1, ticks = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc = 0;
        else          cyc++;
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            pulses.delete();
            prev_e = 1'b0; prev_done = 1'b0; width = 0;
            first_rise = -1; last_fall = -1; done_cyc = -1; ticks = 0;
        end else begin
            if (bus.LCD_E && !prev_e) begin
                cap = {bus.LCD_RS, bus.LCD_D};
                pulses.push_back(cap);
                width = 1;
                if (first_rise < 0) first_rise = cyc;
            end else if (bus.LCD_E) begin
                width++;
                check("rs_d_stable_e_high", int'({bus.LCD_RS, bus.LCD_D}), int'(cap));
            end else if (prev_e) begin
                check("e_width", width, TE);
                check("rs_d_hold", int'({bus.LCD_RS, bus.LCD_D}), int'(cap));
                if (pulses.size() == 5) last_fall = cyc;
            end
            if (bus.init_done && !prev_done) done_cyc = cyc;
            if (bus.frame_tick) begin
                ticks++;
                check("tick_spacing", pulses.size(), 5 + 34 * ticks);
            end
            prev_e    = bus.LCD_E;
            prev_done = bus.init_done;
        end
    end

    // ---------------- helpers ----------------
    function automatic int exp_ref(input int r, input bit hello, input bit a17);
        logic [7:0] ch;
        ch = 8'h20;
        if (r == 0)  return 'h080;
        if (r == 17) return 'h0C0;
        if (hello) begin
            case (r)
                1:       ch = 8'h48;
                2:       ch = 8'h45;
                3, 4:    ch = 8'h4C;
                5:       ch = 8'h4F;
                default: ch = 8'h20;
            endcase
        end
        if (a17 && r == 19) ch = 8'h41;
        return 'h100 | int'(ch);
    endfunction

    task automatic wait_pulses(input int need, input int lim);
        int n = 0;
        while (pulses.size() < need && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("pulse_count_reached", (pulses.size() >= need) ? need : pulses.size(), need);
    endtask

    task automatic write_byte(input logic [4:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] hello_b [5];

    initial begin
        int n;
        hello_b = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_E",    int'(bus.LCD_E), 0);
        check("rst_RS",   int'(bus.LCD_RS), 0);
        check("rst_D",    int'(bus.LCD_D), 0);
        check("rst_done", int'(bus.init_done), 0);
        check("rst_tick", int'(bus.frame_tick), 0);

        @(negedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(5'(i), hello_b[i]);
        bus.wr_en = 1'b0;

        wait_pulses(5, 500);
        check("first_rise_cycle", first_rise, 21);
        check("init0", int'(pulses[0]), 'h038);
        check("init1", int'(pulses[1]), 'h038);
        check("init2", int'(pulses[2]), 'h00C);
        check("init3", int'(pulses[3]), 'h006);
        check("init4", int'(pulses[4]), 'h001);

        n = 0;
        while (done_cyc < 0 && n < 200) begin @(negedge clk); n++; end
        check("init_done_cycle", done_cyc, 65);
        check("clear_gap", done_cyc - last_fall, TCL);

        // Write 'A' to address 17 during the SETUP cycle of character 17.
        n = 0;
        while (!(mk == 5 + 19 && mt == m_start) && n < 1000) begin @(negedge clk); n++; end
        check("reached_char17_setup", int'(bus.LCD_E == 1'b0 && mk == 24), 1);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd17;
        bus.wr_data = 8'h41;
        @(negedge clk);
        bus.wr_en = 1'b0;

        wait_pulses(74, 2000);
        for (int r = 0; r < 34; r++) check($sformatf("pass1_step%0d", r), int'(pulses[5 + r]), exp_ref(r, 1'b1, 1'b0));
        for (int r = 0; r < 34; r++) check($sformatf("pass2_step%0d", r), int'(pulses[39 + r]), exp_ref(r, 1'b1, 1'b1));
        check("wrap_after_char31", int'(pulses[73]), 'h080);
        check("tick_count", ticks, 2);

        // Reset in the middle of a character strobe.
        n = 0;
        while (!(bus.LCD_E && bus.LCD_RS) && n < 500) begin @(negedge clk); n++; end
        check("found_char_strobe", int'(bus.LCD_E && bus.LCD_RS), 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_E_drop",    int'(bus.LCD_E), 0);
        check("async_done_drop", int'(bus.init_done), 0);
        check("async_D_clear",   int'(bus.LCD_D), 0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        wait_pulses(40, 1000);
        check("restart_first_rise", first_rise, 21);
        check("restart_init0", int'(pulses[0]), 'h038);
        for (int r = 0; r < 34; r++) check($sformatf("restart_step%0d", r), int'(pulses[5 + r]), exp_ref(r, 1'b0, 1'b0));
        check("restart_wrap", int'(pulses[39]), 'h080);
        check("restart_ticks", ticks, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
